// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out handshake bundle for imm_gen_pipe.
// master = producer of instructions and consumer of immediates (decode/ALU side),
// slave  = the immediate generator itself.
interface imm_gen_pipe_if #(
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_imm;
  logic [2:0]         out_kind;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_kind
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_kind
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator for the TSC decode stage.
// Extends/positions the immediate or jump target of an instruction per opcode
// and holds results in a 2-entry skid buffer (main M drives outputs, skid S
// absorbs one word while the consumer stalls) so in_ready is a pure register.
// Optional macro IMM_GEN_BYPASS_EN: when empty and the consumer is ready, the
// extended value goes straight through in the same cycle without being stored.
module imm_gen_pipe #(
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 16,
  parameter int OPC_W   = 4,
  parameter int IMM_W   = 8,
  parameter int TGT_W   = 12
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    K_SEXT = 3'd0,
    K_ZEXT = 3'd1,
    K_HIGH = 3'd2,
    K_TGT  = 3'd3,
    K_NONE = 3'd4
  } kind_e;

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    kind_e             kind;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e             state;
  ent_t               m_ent;
  ent_t               s_ent;
  logic               m_vld;
  logic               rdy;
  ent_t               ext;
  logic [OPC_W-1:0]   opc;
  logic               accept;
  logic               pop;
  logic               byp;

  // Decode the opcode and build the extended immediate for the incoming word.
  always_comb begin
    ext  = '0;
    opc  = bus.in_instr[INSTR_W-1 -: OPC_W];
    case (int'(opc))
      0, 1, 2, 3, 4, 7, 8: begin
        // Branches, ADI, LWD, SWD: signed displacement / immediate.
        for (int i = 0; i < DATA_W; i++) begin
          if (i < IMM_W) ext.imm[i] = bus.in_instr[i];
          else           ext.imm[i] = bus.in_instr[IMM_W-1];
        end
        ext.kind = K_SEXT;
      end
      5: begin
        // ORI: logical operand, no sign.
        ext.imm[IMM_W-1:0] = bus.in_instr[IMM_W-1:0];
        ext.kind           = K_ZEXT;
      end
      6: begin
        // LHI: field lands in the top byte(s), low bits cleared.
        ext.imm[DATA_W-1 -: IMM_W] = bus.in_instr[IMM_W-1:0];
        ext.kind                   = K_HIGH;
      end
      9, 10: begin
        // JMP/JAL: raw target field; PC upper bits are merged downstream.
        ext.imm[TGT_W-1:0] = bus.in_instr[TGT_W-1:0];
        ext.kind           = K_TGT;
      end
      default: begin
        ext.imm  = '0;
        ext.kind = K_NONE;
      end
    endcase
  end

`ifdef IMM_GEN_BYPASS_EN
  // Same-cycle pass-through only when nothing is buffered, so ordering holds.
  assign byp = (state == EMPTY) & bus.in_valid & bus.out_ready & ~flush;
`else
  assign byp = 1'b0;
`endif

  assign accept = bus.in_valid & rdy;
  assign pop    = m_vld & bus.out_ready;

  // Skid-buffer state machine; flush outranks every transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      m_ent <= '0;
      s_ent <= '0;
      m_vld <= 1'b0;
      rdy   <= 1'b1;
    end else if (flush) begin
      // Payload registers are held; they are don't-care while out_valid=0.
      state <= EMPTY;
      m_vld <= 1'b0;
      rdy   <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept && !byp) begin
            m_ent <= ext;
            m_vld <= 1'b1;
            state <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            m_ent <= ext;
          end else if (accept) begin
            s_ent <= ext;
            rdy   <= 1'b0;
            state <= TWO;
          end else if (pop) begin
            m_vld <= 1'b0;
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            m_ent <= s_ent;
            rdy   <= 1'b1;
            state <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
          m_vld <= 1'b0;
          rdy   <= 1'b1;
        end
      endcase
    end
  end

  // Outputs come from M; bypass (if built) substitutes the live extension.
  assign bus.in_ready  = rdy;
  assign bus.out_valid = m_vld | byp;
  assign bus.out_imm   = byp ? ext.imm : m_ent.imm;
  assign bus.out_kind  = byp ? ext.kind : m_ent.kind;

endmodule
